// File: rtl/phy_rx_serial_paralelo.sv
// phy_rx_serial_paralelo
// Receive-side deserializer. It shifts in one line bit per clk_32f edge with
// the MSB first. It aligns to words on the COMMA pattern and declares the link
// active after BC_REQUIRED consecutive aligned commas. Once active, it delivers
// one 8-bit word every 8 edges and flags payload words, i.e. words that are
// neither COMMA nor IDLE.
module phy_rx_serial_paralelo #(
    parameter logic [7:0] COMMA       = 8'hBC,
    parameter logic [7:0] IDLE        = 8'h7C,
    parameter int         BC_REQUIRED = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       word_strobe,
    output logic       active
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        COUNT  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] BC_REQ_C = BC_REQUIRED[3:0];

    // Only the seven most recent bits are needed, because the candidate word
    // is completed by the bit arriving on the current edge.
    logic [6:0] sr_q;
    logic [2:0] bit_cnt_q;
    logic [3:0] bc_cnt_q;
    state_t     state_q;
    logic [7:0] data_q;
    logic       valid_q;
    logic       strobe_q;
    logic       active_q;

    logic [7:0] cand_s;
    logic       boundary_s;
    logic [3:0] bc_next_s;

    assign cand_s     = {sr_q, data_in};
    assign boundary_s = (bit_cnt_q == 3'd7);
    assign bc_next_s  = bc_cnt_q + 4'd1;

    // Shift register, alignment FSM and registered word outputs.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            sr_q      <= 7'd0;
            bit_cnt_q <= 3'd0;
            bc_cnt_q  <= 4'd0;
            state_q   <= SEARCH;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            strobe_q  <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            sr_q     <= cand_s[6:0];
            strobe_q <= 1'b0;
            case (state_q)
                SEARCH: begin
                    // A comma may be found at any bit offset. The next edge
                    // then carries the MSB of the following word.
                    bit_cnt_q <= 3'd0;
                    if (cand_s == COMMA) begin
                        bc_cnt_q <= 4'd1;
                        if (BC_REQ_C == 4'd1) begin
                            state_q  <= ACTIVE;
                            active_q <= 1'b1;
                        end else begin
                            state_q <= COUNT;
                        end
                    end else begin
                        bc_cnt_q <= 4'd0;
                    end
                end
                COUNT: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (boundary_s) begin
                        if (cand_s == COMMA) begin
                            bc_cnt_q <= bc_next_s;
                            if (bc_next_s == BC_REQ_C) begin
                                state_q  <= ACTIVE;
                                active_q <= 1'b1;
                            end else begin
                                state_q <= COUNT;
                            end
                        end else begin
                            bc_cnt_q <= 4'd0;
                            state_q  <= SEARCH;
                        end
                    end else begin
                        bc_cnt_q <= bc_cnt_q;
                    end
                end
                ACTIVE: begin
                    // The link stays aligned until reset. Commas that straddle
                    // a word edge are ignored.
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    active_q  <= 1'b1;
                    if (boundary_s) begin
                        data_q   <= cand_s;
                        valid_q  <= (cand_s != COMMA) && (cand_s != IDLE);
                        strobe_q <= 1'b1;
                    end else begin
                        data_q <= data_q;
                    end
                end
                default: begin
                    bit_cnt_q <= 3'd0;
                    bc_cnt_q  <= 4'd0;
                    state_q   <= SEARCH;
                    active_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign word_strobe = strobe_q;
    assign active      = active_q;

endmodule

// File: tb/tb_phy_rx_serial_paralelo.sv
// Directed bench for phy_rx_serial_paralelo.
// It uses a word table for the main stream plus hand sequences for the corners.
module tb_phy_rx_serial_paralelo;

    logic       clk_32f;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       word_strobe;
    logic       active;

    int errors;
    int checks;

    phy_rx_serial_paralelo dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .data_in    (data_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .word_strobe(word_strobe),
        .active     (active)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    typedef struct {
        logic [7:0] word;
        logic       exp_active;
        logic       exp_strobe;
        logic [7:0] exp_data;
        logic       exp_valid;
    } vec_t;

    vec_t vecs [0:15];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one bit, let the DUT sample it, and settle just after the edge.
    task automatic tick(input logic b, input logic r);
        data_in = b;
        reset   = r;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w);
        logic [7:0] t;
        t = w;
        for (int i = 7; i >= 0; i--) tick(t[i], 1'b0);
    endtask

    task automatic chk_all(input string tag, input logic a, input logic s,
                           input logic [7:0] d, input logic v);
        chk({tag, ".active"}, {7'd0, active}, {7'd0, a});
        chk({tag, ".strobe"}, {7'd0, word_strobe}, {7'd0, s});
        chk({tag, ".data"}, data_out, d);
        chk({tag, ".valid"}, {7'd0, valid_out}, {7'd0, v});
    endtask

    initial begin
        logic [7:0] prev_d;
        logic       prev_v;
        logic [7:0] w;
        errors  = 0;
        checks  = 0;
        data_in = 1'b0;
        reset   = 1'b1;

        vecs[0]  = '{8'hBC, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{8'hBC, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{8'hBC, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{8'hBC, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[4]  = '{8'h7C, 1'b1, 1'b1, 8'h7C, 1'b0};
        vecs[5]  = '{8'h7C, 1'b1, 1'b1, 8'h7C, 1'b0};
        vecs[6]  = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1};
        vecs[7]  = '{8'hEE, 1'b1, 1'b1, 8'hEE, 1'b1};
        vecs[8]  = '{8'hDD, 1'b1, 1'b1, 8'hDD, 1'b1};
        vecs[9]  = '{8'hCC, 1'b1, 1'b1, 8'hCC, 1'b1};
        vecs[10] = '{8'h7C, 1'b1, 1'b1, 8'h7C, 1'b0};
        vecs[11] = '{8'hBC, 1'b1, 1'b1, 8'hBC, 1'b0};
        vecs[12] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b1};
        // 0x0B,0xC0 hide a comma across the word edge; alignment must not move.
        vecs[13] = '{8'h0B, 1'b1, 1'b1, 8'h0B, 1'b1};
        vecs[14] = '{8'hC0, 1'b1, 1'b1, 8'hC0, 1'b1};
        vecs[15] = '{8'h11, 1'b1, 1'b1, 8'h11, 1'b1};

        // Reset held for 3 cycles with data_in = 1, then the first edge after release.
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1);
            chk_all("rst_hold", 1'b0, 1'b0, 8'h00, 1'b0);
        end
        tick(1'b1, 1'b0);
        chk_all("rst_rel", 1'b0, 1'b0, 8'h00, 1'b0);
        tick(1'b0, 1'b1);

        // Main table: sync, idle, payload and hold checks.
        prev_d = 8'h00;
        prev_v = 1'b0;
        for (int k = 0; k < 16; k++) begin
            w = vecs[k].word;
            for (int i = 7; i >= 0; i--) begin
                tick(w[i], 1'b0);
                if (i == 4) begin
                    chk($sformatf("v%0d.mid_strobe", k), {7'd0, word_strobe}, 8'd0);
                    chk($sformatf("v%0d.hold_data", k), data_out, prev_d);
                    chk($sformatf("v%0d.hold_valid", k), {7'd0, valid_out}, {7'd0, prev_v});
                end
            end
            chk_all($sformatf("v%0d", k), vecs[k].exp_active, vecs[k].exp_strobe,
                    vecs[k].exp_data, vecs[k].exp_valid);
            prev_d = vecs[k].exp_data;
            prev_v = vecs[k].exp_valid;
        end

        // Broken run: 3 commas, then 0x55, then 4 commas. Activation comes at bit edge 64.
        tick(1'b0, 1'b1);
        for (int k = 0; k < 3; k++) send_word(8'hBC);
        chk("brk.after3", {7'd0, active}, 8'd0);
        send_word(8'h55);
        chk("brk.after55", {7'd0, active}, 8'd0);
        for (int k = 0; k < 3; k++) send_word(8'hBC);
        chk("brk.after7", {7'd0, active}, 8'd0);
        w = 8'hBC;
        for (int i = 7; i >= 1; i--) tick(w[i], 1'b0);
        chk("brk.edge63", {7'd0, active}, 8'd0);
        tick(w[0], 1'b0);
        chk("brk.edge64", {7'd0, active}, 8'd1);
        chk("brk.nostrobe", {7'd0, word_strobe}, 8'd0);

        // Bit slip: junk bits 1,0,1, then 4 commas, then 0xAA.
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) send_word(8'hBC);
        chk("slip.after3", {7'd0, active}, 8'd0);
        send_word(8'hBC);
        chk("slip.after4", {7'd0, active}, 8'd1);
        send_word(8'hAA);
        chk_all("slip.aa", 1'b1, 1'b1, 8'hAA, 1'b1);

        // Reset mid-ACTIVE, mid-word. Four new commas are needed to reactivate.
        w = 8'h12;
        for (int i = 7; i >= 5; i--) tick(w[i], 1'b0);
        tick(1'b1, 1'b1);
        chk_all("midrst", 1'b0, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) send_word(8'hBC);
        chk_all("midrst.after3", 1'b0, 1'b0, 8'h00, 1'b0);
        send_word(8'hBC);
        chk_all("midrst.after4", 1'b1, 1'b0, 8'h00, 1'b0);
        send_word(8'h33);
        chk_all("midrst.w33", 1'b1, 1'b1, 8'h33, 1'b1);
        tick(1'b0, 1'b0);
        chk("midrst.strobe_drop", {7'd0, word_strobe}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
